// File: rtl/tilemap_pkg.sv
// Shared constants, FSM encoding and address helper for the tile-map arbiter.
package tilemap_pkg;
   localparam int NCOL     = 40;
   localparam int NROW     = 30;
   localparam int MAP_SIZE = NCOL * NROW;
   localparam int AW       = 11;
   localparam int TW       = 4;
   localparam int H_TOTAL  = 800;
   localparam int V_TOTAL  = 525;
   localparam int V_ACTIVE = 480;

   typedef enum logic {IDLE, CLEAR} state_t;

   // row*40+col without a multiplier
   function automatic logic [AW-1:0] map_addr(input logic [5:0] row, input logic [5:0] col);
      return ({5'd0, row} << 5) + ({5'd0, row} << 3) + {5'd0, col};
   endfunction
endpackage

// File: rtl/tilemap_ram.sv
// 1200x4 single-port synchronous RAM, registered read, for block-RAM inference.
module tilemap_ram import tilemap_pkg::*; (
   input  logic          px_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [TW-1:0] i_wdata,
   output logic [TW-1:0] o_q
);
   logic [TW-1:0] r_mem [0:MAP_SIZE-1];

   always_ff @(posedge px_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      o_q <= r_mem[i_addr];
   end
endmodule

// File: rtl/tilemap_arbiter.sv
// Tile-map RAM owner: fixed-slot video fetch, handshaked game writer, clear engine, frame tick.
module tilemap_arbiter import tilemap_pkg::*; (
   input  logic        px_clk,
   input  logic        rstn,
   input  logic [9:0]  x_px,
   input  logic [9:0]  y_px,
   output logic [3:0]  tile_idx,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [5:0]  wr_col,
   input  logic [4:0]  wr_row,
   input  logic [3:0]  wr_tile,
   output logic        wr_oob,
   input  logic        clr_req,
   input  logic [3:0]  clr_tile,
   output logic        clr_busy,
   output logic        frame_tick
);
   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_clr_cnt, w_clr_cnt_nxt;
   logic [TW-1:0] r_fill, w_fill_nxt;
   logic [TW-1:0] r_tile;
   logic          r_vid_d, r_oob, r_tick;
   logic          w_col_slot, w_eol_slot, w_vid_slot;
   logic [9:0]    w_y_nxt;
   logic [5:0]    w_vcol, w_vrow;
   logic          w_wr_xfer, w_wr_inrange, w_we;
   logic [AW-1:0] w_addr;
   logic [TW-1:0] w_wdata, w_ram_q;

   // Each column is fetched 2 clocks before its 16-px span; column 0 comes from the previous line's tail.
   assign w_col_slot = (x_px[3:0] == 4'd14) && (x_px < 10'(16*NCOL-2));
   assign w_eol_slot = (x_px == 10'(H_TOTAL-2));
   assign w_vid_slot = w_col_slot | w_eol_slot;
   assign w_y_nxt    = (y_px == 10'(V_TOTAL-1)) ? 10'd0 : y_px + 10'd1;
   assign w_vrow     = w_eol_slot ? w_y_nxt[9:4] : y_px[9:4];
   assign w_vcol     = w_eol_slot ? 6'd0 : x_px[9:4] + 6'd1;

   assign w_wr_inrange = (wr_col < 6'(NCOL)) && (wr_row < 5'(NROW));
   assign wr_ready     = (r_state == IDLE) && !w_vid_slot;
   assign w_wr_xfer    = wr_valid && wr_ready;
   assign clr_busy     = (r_state == CLEAR);

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      w_fill_nxt    = r_fill;
      w_we          = 1'b0;
      w_addr        = map_addr(w_vrow, w_vcol);
      w_wdata       = wr_tile;
      case (r_state)
         IDLE: begin
            if (!w_vid_slot) begin
               w_addr = map_addr({1'b0, wr_row}, wr_col);
               w_we   = w_wr_xfer && w_wr_inrange;
            end
            // the state change needs no RAM port, so a request in a slot cycle still counts
            if (clr_req) begin
               w_state_nxt   = CLEAR;
               w_clr_cnt_nxt = '0;
               w_fill_nxt    = clr_tile;
            end
         end
         CLEAR: begin
            if (!w_vid_slot) begin
               w_addr  = r_clr_cnt;
               w_wdata = r_fill;
               w_we    = 1'b1;
               if (r_clr_cnt == AW'(MAP_SIZE-1)) w_state_nxt = IDLE;
               else w_clr_cnt_nxt = r_clr_cnt + AW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge px_clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_clr_cnt <= '0;
         r_fill    <= '0;
         r_vid_d   <= 1'b0;
         r_tile    <= '0;
         r_oob     <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
         r_fill    <= w_fill_nxt;
         r_vid_d   <= w_vid_slot;
         if (r_vid_d) r_tile <= w_ram_q;
         r_oob     <= w_wr_xfer && !w_wr_inrange;
         r_tick    <= (x_px == 10'd0) && (y_px == 10'(V_ACTIVE));
      end
   end

   assign tile_idx   = r_tile;
   assign wr_oob     = r_oob;
   assign frame_tick = r_tick;

   tilemap_ram u_ram (
      .px_clk  (px_clk),
      .i_we    (w_we),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .o_q     (w_ram_q)
   );
endmodule

// File: tb/tb_tilemap_arbiter.sv
// Self-checking bench for tilemap_arbiter: vector table, directed corner sequences, random traffic vs a map model.
module tb_tilemap_arbiter;
   logic       px_clk = 1'b0, rstn = 1'b0;
   logic [9:0] x_px = '0, y_px = '0;
   logic [3:0] tile_idx;
   logic       wr_valid = 1'b0, wr_ready;
   logic [5:0] wr_col = '0;
   logic [4:0] wr_row = '0;
   logic [3:0] wr_tile = '0;
   logic       wr_oob;
   logic       clr_req = 1'b0;
   logic [3:0] clr_tile = '0;
   logic       clr_busy, frame_tick;

   int checks = 0, failures = 0;

   always #5 px_clk = ~px_clk;

   tilemap_arbiter dut (
      .px_clk(px_clk), .rstn(rstn), .x_px(x_px), .y_px(y_px), .tile_idx(tile_idx),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
      .wr_tile(wr_tile), .wr_oob(wr_oob), .clr_req(clr_req), .clr_tile(clr_tile),
      .clr_busy(clr_busy), .frame_tick(frame_tick)
   );

   // reference model: the map as a plain array plus "what the outputs should be now"
   int  mmap[1200];
   bit  mknown[1200];
   bit  m_busy, m_oob, m_tick;
   int  m_idx, m_fill;
   int  exp_tile;
   bit  exp_known;
   typedef struct {longint due; int val; bit known;} fetch_t;
   fetch_t fq[$];
   longint cnum = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d cyc=%0d)", name, act, exp, x_px, y_px, cnum);
      end
   endtask

   function automatic bit is_slot(input int x);
      return (x == 798) || (((x + 2) % 16 == 0) && ((x + 2) / 16 >= 1) && ((x + 2) / 16 <= 39));
   endfunction

   task automatic mreset();
      m_busy = 0; m_oob = 0; m_tick = 0;
      exp_tile = 0; exp_known = 1;
      fq.delete();
   endtask

   // one clock: compare at negedge, advance the model at posedge, return at posedge+1
   task automatic cyc();
      bit s, noob;
      int c, r;
      @(negedge px_clk);
      while (fq.size() > 0 && fq[0].due <= cnum) begin
         exp_tile = fq[0].val; exp_known = fq[0].known;
         void'(fq.pop_front());
      end
      s = is_slot(int'(x_px));
      chk("wr_ready", wr_ready, int'(!m_busy && !s));
      chk("clr_busy", clr_busy, m_busy);
      chk("wr_oob", wr_oob, m_oob);
      chk("frame_tick", frame_tick, m_tick);
      if (exp_known) chk("tile_idx", tile_idx, exp_tile);
      @(posedge px_clk);
      if (s) begin
         if (x_px == 10'd798) begin c = 0; r = ((int'(y_px) + 1) % 525) / 16; end
         else begin c = (int'(x_px) + 2) / 16; r = int'(y_px) / 16; end
         if (r < 30) fq.push_back('{cnum + 2, mmap[r*40+c], mknown[r*40+c]});
         else fq.push_back('{cnum + 2, 0, 1'b0});
      end
      noob = 0;
      if (!m_busy) begin
         if (wr_valid && !s) begin
            if (wr_col < 40 && wr_row < 30) begin
               mmap[int'(wr_row)*40 + int'(wr_col)]   = int'(wr_tile);
               mknown[int'(wr_row)*40 + int'(wr_col)] = 1;
            end else noob = 1;
         end
         if (clr_req) begin m_busy = 1; m_idx = 0; m_fill = int'(clr_tile); end
      end else if (!s) begin
         mmap[m_idx] = m_fill; mknown[m_idx] = 1;
         m_idx++;
         if (m_idx == 1200) m_busy = 0;
      end
      m_oob  = noob;
      m_tick = (x_px == 10'd0) && (y_px == 10'd480);
      #1;
      cnum++;
   endtask

   task automatic adv();
      if (x_px == 10'd799) begin
         x_px = '0;
         y_px = (y_px == 10'd524) ? 10'd0 : y_px + 10'd1;
      end else x_px = x_px + 10'd1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin cyc(); adv(); end
   endtask

   // sweep one visible line of row r; fill >= 0 also checks every tile against a constant
   task automatic scan_row(input int r, input int fill);
      int line;
      line = 16*r + 7;
      y_px = 10'(line - 1); x_px = 10'd790;
      for (int i = 0; i < 810; i++) begin
         if (fill >= 0 && int'(y_px) == line && x_px < 10'd640 && x_px[3:0] == 4'd8)
            chk("scan_tile", tile_idx, fill);
         cyc(); adv();
      end
   endtask

   task automatic wait_clear(input string name);
      int n;
      n = 0;
      while (clr_busy && n < 2000) begin cyc(); adv(); n++; end
      chk(name, int'(n < 2000), 1);
   endtask

   typedef struct {int x; int y; bit rdy; bit tick;} vec_t;
   vec_t tbl[15];

   initial begin
      int busy_cnt, slot_cnt, tcnt;
      tbl[0]  = '{13, 0, 1, 0};   tbl[1]  = '{14, 0, 0, 0};   tbl[2]  = '{15, 0, 1, 0};
      tbl[3]  = '{30, 5, 0, 0};   tbl[4]  = '{31, 5, 1, 0};   tbl[5]  = '{622, 100, 0, 0};
      tbl[6]  = '{638, 100, 1, 0}; tbl[7] = '{797, 0, 1, 0};  tbl[8]  = '{798, 0, 0, 0};
      tbl[9]  = '{798, 524, 0, 0}; tbl[10] = '{0, 480, 1, 1}; tbl[11] = '{1, 480, 1, 0};
      tbl[12] = '{0, 479, 1, 0};  tbl[13] = '{0, 481, 1, 0};  tbl[14] = '{0, 0, 1, 0};

      // reset: outputs low even with the tick condition present on the inputs
      x_px = 10'd0; y_px = 10'd480;
      repeat (3) begin
         @(negedge px_clk);
         chk("rst_tile", tile_idx, 0); chk("rst_oob", wr_oob, 0);
         chk("rst_busy", clr_busy, 0); chk("rst_tick", frame_tick, 0);
      end
      @(posedge px_clk); #1;
      x_px = 10'd100; y_px = 10'd0; rstn = 1'b1;
      mreset();

      for (int i = 0; i < 15; i++) begin
         x_px = 10'(tbl[i].x); y_px = 10'(tbl[i].y);
         #1 chk("tbl_ready", wr_ready, tbl[i].rdy);
         cyc();
         chk("tbl_tick", frame_tick, tbl[i].tick);
      end

      // clear to 7, requested in a slot cycle; a second request and a writer mid-clear are ignored
      x_px = 10'd622; y_px = 10'd100; clr_req = 1; clr_tile = 4'd7;
      #1 chk("clr_slot_ready", wr_ready, 0);
      cyc(); clr_req = 0; adv();
      busy_cnt = 0; slot_cnt = 0;
      wr_valid = 1; wr_col = 6'd1; wr_row = 5'd1; wr_tile = 4'd9;
      while (clr_busy && busy_cnt < 2000) begin
         busy_cnt++;
         if (is_slot(int'(x_px))) slot_cnt++;
         if (busy_cnt == 50) begin clr_req = 1; clr_tile = 4'd3; end
         cyc(); clr_req = 0; adv();
      end
      wr_valid = 0;
      chk("clr_len", busy_cnt, 1200 + slot_cnt);
      for (int r = 0; r < 30; r++) scan_row(r, 7);

      // plain write away from slots, seen on line 32 at x 48..63
      x_px = 10'd100; y_px = 10'd0;
      wr_valid = 1; wr_col = 6'd3; wr_row = 5'd2; wr_tile = 4'd5;
      #1 chk("wr_ready_idle", wr_ready, 1);
      cyc(); wr_valid = 0;
      x_px = 10'd40; y_px = 10'd32;
      for (int i = 0; i < 31; i++) begin
         if (x_px >= 10'd48 && x_px <= 10'd63) chk("line32_tile", tile_idx, 5);
         cyc(); adv();
      end

      // writer held across the x=30 slot
      x_px = 10'd30; y_px = 10'd200;
      wr_valid = 1; wr_col = 6'd10; wr_row = 5'd5; wr_tile = 4'd9;
      #1 chk("stall_ready", wr_ready, 0);
      cyc(); adv();
      #1 chk("stall_go", wr_ready, 1);
      cyc(); wr_valid = 0; adv();

      // out-of-range columns and rows: accepted, discarded, one oob pulse each
      for (int k = 0; k < 2; k++) begin
         x_px = 10'd100; y_px = 10'd0;
         wr_valid = 1; wr_col = (k == 0) ? 6'd40 : 6'd0; wr_row = (k == 0) ? 5'd0 : 5'd30; wr_tile = 4'd15;
         #1 chk("oob_ready", wr_ready, 1);
         cyc(); wr_valid = 0; adv();
         chk("oob_pulse", wr_oob, 1);
         cyc(); adv();
         chk("oob_once", wr_oob, 0);
      end
      scan_row(0, 7); scan_row(1, 7); scan_row(2, -1); scan_row(5, -1);

      // frame tick once per frame; column-0 fetch at the frame wrap reads row 0
      for (int f = 0; f < 2; f++) begin
         x_px = 10'd790; y_px = 10'd479; tcnt = 0;
         for (int i = 0; i < 30; i++) begin cyc(); adv(); if (frame_tick) tcnt++; end
         chk("tick_once", tcnt, 1);
      end
      x_px = 10'd790; y_px = 10'd524;
      run(15);
      chk("wrap_fetch", tile_idx, 7);

      // write and clear request together: write lands, then the clear runs
      x_px = 10'd100; y_px = 10'd0;
      wr_valid = 1; wr_col = 6'd5; wr_row = 5'd5; wr_tile = 4'd2; clr_req = 1; clr_tile = 4'd1;
      #1 chk("both_ready", wr_ready, 1);
      cyc(); wr_valid = 0; clr_req = 0; adv();
      chk("both_busy", clr_busy, 1);
      wait_clear("clr2_timeout");
      scan_row(5, 1);

      // random traffic
      x_px = 10'($urandom_range(0, 799)); y_px = 10'($urandom_range(0, 524));
      for (int i = 0; i < 8000; i++) begin
         wr_valid = 1'($urandom % 2);
         wr_col   = 6'($urandom_range(0, 43));
         wr_row   = 5'($urandom_range(0, 32));
         wr_tile  = 4'($urandom);
         clr_req  = ($urandom % 3000) == 0;
         clr_tile = 4'($urandom);
         cyc(); adv();
         if (x_px == 10'd0 && ($urandom % 2) == 1) y_px = 10'($urandom_range(0, 524));
      end
      wr_valid = 0; clr_req = 0;
      wait_clear("clr3_timeout");
      for (int r = 0; r < 30; r += 7) scan_row(r, -1);

      // reset in the middle of a clear leaves the map partly cleared
      x_px = 10'd100; y_px = 10'd0; clr_req = 1; clr_tile = 4'd12;
      cyc(); clr_req = 0; adv();
      run(300);
      rstn = 1'b0;
      #1 chk("midrst_busy", clr_busy, 0);
      chk("midrst_tile", tile_idx, 0);
      @(posedge px_clk); #1;
      rstn = 1'b1; mreset();
      scan_row(0, 12); scan_row(29, -1);
      x_px = 10'd100; y_px = 10'd0;
      #1 chk("post_rst_ready", wr_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
